// File: rtl/ethernet_mmio_adapter.sv
// ethernet_mmio_adapter
// Front-end that turns a valid/ready MMIO request/response stream into the
// ethernet controller's strobe interface.
//
// Handshake semantics (both channels): a beat transfers on a rising clock
// edge where valid and ready are both high. A producer holds valid and its
// payload stable until the transfer. Ready may depend combinationally on the
// consumer's own state and on resp_ready_and_i, but never on req_v_i.
//
// Flow: an accepted request drives the controller strobes in its transfer
// cycle. {w, off, size, err} is captured into a one-entry pipeline register.
// One cycle later the controller's sync-read data is formatted and pushed
// into the response FIFO. Every request produces exactly one response, so
// responses come back in request order. A credit counter bounds the number of
// outstanding requests (pipeline plus FIFO) to the FIFO depth, which means the
// FIFO can never overflow. A credit returned by a response pop is usable in
// the same cycle. This sustains one request per cycle while the response
// consumer keeps up, even though three requests are in flight in the steady
// state.
module ethernet_mmio_adapter #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 14,
  parameter int resp_els_p   = 2
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic                                       req_v_i,
  output logic                                       req_ready_and_o,
  input  logic                                       req_w_i,
  input  logic [addr_width_p-1:0]                    req_addr_i,
  input  logic [$clog2($clog2(data_width_p/8)+1)-1:0] req_size_i,
  input  logic [data_width_p-1:0]                    req_data_i,
  output logic                                       resp_v_o,
  input  logic                                       resp_ready_and_i,
  output logic [data_width_p-1:0]                    resp_data_o,
  output logic                                       resp_err_o,
  output logic [addr_width_p-1:0]                    addr_o,
  output logic                                       write_en_o,
  output logic                                       read_en_o,
  output logic [data_width_p/8-1:0]                  write_mask_o,
  output logic [data_width_p-1:0]                    write_data_o,
  input  logic [data_width_p-1:0]                    read_data_i
);

  localparam int bytes_lp = data_width_p / 8;
  localparam int ow_lp    = $clog2(bytes_lp);
  localparam int sw_lp    = $clog2(ow_lp + 1);
  localparam int cw_lp    = $clog2(resp_els_p + 1);
  localparam int pw_lp    = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;

  // ---------------------------------------------------------------------
  // Issue stage (combinational from the request)
  // ---------------------------------------------------------------------
  logic                    xfer;
  logic                    resp_hs;
  logic [ow_lp-1:0]        off;
  logic                    size_ok;
  logic                    off_low;
  logic                    misaligned;
  int                      sz;
  logic [bytes_lp-1:0]     lane_mask;
  logic [data_width_p-1:0] rep_data;
  logic [cw_lp-1:0]        credits;

  // Alignment check, byte-lane selection and lane replication of write data.
  // A lane belongs to the access when it sits in the same size-aligned block
  // as the offset; for an aligned access those are exactly lanes off..off+nb-1.
  always_comb begin
    off        = req_addr_i[ow_lp-1:0];
    size_ok    = (int'(req_size_i) <= ow_lp);
    off_low    = 1'b0;
    for (int i = 0; i < ow_lp; i++) begin
      if (i < int'(req_size_i)) off_low = off_low | off[i];
    end
    misaligned = !size_ok || off_low;
    sz         = size_ok ? int'(req_size_i) : ow_lp;
    lane_mask  = '0;
    rep_data   = '0;
    for (int i = 0; i < bytes_lp; i++) begin
      lane_mask[i]       = ((i >> sz) == (int'(off) >> sz));
      rep_data[8*i +: 8] = req_data_i[8*(i & ((1 << sz) - 1)) +: 8];
    end
  end

  // A pop this cycle frees a slot immediately, so it can back a new request.
  assign resp_hs         = resp_v_o && resp_ready_and_i;
  assign req_ready_and_o = !reset_i && ((credits != '0) || resp_hs);
  assign xfer            = req_v_i && req_ready_and_o;

  assign read_en_o    = xfer && !req_w_i && !misaligned;
  assign write_en_o   = xfer &&  req_w_i && !misaligned;
  assign write_mask_o = write_en_o ? lane_mask : '0;
  assign write_data_o = xfer ? rep_data : '0;
  assign addr_o       = xfer ? {req_addr_i[addr_width_p-1:ow_lp], {ow_lp{1'b0}}} : '0;

  // ---------------------------------------------------------------------
  // Pipeline register: remembers how to format the response next cycle
  // ---------------------------------------------------------------------
  logic             valid_r;
  logic             w_r;
  logic [ow_lp-1:0] off_r;
  logic [sw_lp-1:0] size_r;
  logic             err_r;

  // Capture request attributes on transfer; the valid bit tracks transfers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_r <= 1'b0;
      w_r     <= 1'b0;
      off_r   <= '0;
      size_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= xfer;
      if (xfer) begin
        w_r    <= req_w_i;
        off_r  <= off;
        size_r <= req_size_i;
        err_r  <= misaligned;
      end
    end
  end

  logic [data_width_p-1:0] resp_fmt;

  // Right-align the read data by the captured offset and zero bytes beyond the
  // access size. Writes and errored requests answer with zero data.
  always_comb begin
    resp_fmt = '0;
    if (!w_r && !err_r) begin
      for (int i = 0; i < bytes_lp; i++) begin
        if ((i < (1 << int'(size_r))) && ((i + int'(off_r)) < bytes_lp)) begin
          resp_fmt[8*i +: 8] = read_data_i[8*(i + int'(off_r)) +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------
  logic                    push;
  logic                    pop;
  logic [pw_lp-1:0]        wr_ptr;
  logic [pw_lp-1:0]        rd_ptr;
  logic [cw_lp-1:0]        count;
  logic [data_width_p-1:0] data_mem [resp_els_p];
  logic                    err_mem  [resp_els_p];

  function automatic logic [pw_lp-1:0] ptr_inc(input logic [pw_lp-1:0] p);
    return (p == pw_lp'(resp_els_p - 1)) ? '0 : p + pw_lp'(1);
  endfunction

  assign push        = valid_r;
  assign pop         = resp_hs;
  assign resp_v_o    = (count != '0);
  assign resp_data_o = resp_v_o ? data_mem[rd_ptr] : '0;
  assign resp_err_o  = resp_v_o ? err_mem[rd_ptr]  : 1'b0;

  // Storage writes; contents are don't-care until counted in.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr] <= resp_fmt;
      err_mem[wr_ptr]  <= err_r;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + cw_lp'(1);
        2'b01:   count <= count - cw_lp'(1);
        default: count <= count;
      endcase
    end
  end

  // Credit counter: one credit per free response slot, taken on request
  // transfer and returned on response handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits <= cw_lp'(resp_els_p);
    end else begin
      case ({xfer, resp_hs})
        2'b10:   credits <= credits - cw_lp'(1);
        2'b01:   credits <= credits + cw_lp'(1);
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_mmio_adapter.sv
// Directed bench for ethernet_mmio_adapter (32-bit data, 14-bit address,
// 2-entry response FIFO). Inputs change 1 time unit after the rising edge.
// Outputs are sampled on the falling edge.
module tb_ethernet_mmio_adapter;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic        req_v_i;
  logic        req_ready_and_o;
  logic        req_w_i;
  logic [13:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_data_i;
  logic        resp_v_o;
  logic        resp_ready_and_i;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic [13:0] addr_o;
  logic        write_en_o;
  logic        read_en_o;
  logic [3:0]  write_mask_o;
  logic [31:0] write_data_o;
  logic [31:0] read_data_i = 32'h0;

  ethernet_mmio_adapter dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .req_v_i          (req_v_i),
    .req_ready_and_o  (req_ready_and_o),
    .req_w_i          (req_w_i),
    .req_addr_i       (req_addr_i),
    .req_size_i       (req_size_i),
    .req_data_i       (req_data_i),
    .resp_v_o         (resp_v_o),
    .resp_ready_and_i (resp_ready_and_i),
    .resp_data_o      (resp_data_o),
    .resp_err_o       (resp_err_o),
    .addr_o           (addr_o),
    .write_en_o       (write_en_o),
    .read_en_o        (read_en_o),
    .write_mask_o     (write_mask_o),
    .write_data_o     (write_data_o),
    .read_data_i      (read_data_i)
  );

  // scoreboard state
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] exp_q[$];  // {err, data}, in request order

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Controller register contents seen through the sync-read port.
  function automatic logic [31:0] mem_word(input logic [13:0] a);
    if (a == 14'h0200) return 32'hAABBCCDD;
    return {2'b10, ~a, 2'b01, a};
  endfunction

  // Controller model: read data appears one cycle after read_en_o.
  always @(posedge clk) read_data_i <= read_en_o ? mem_word(addr_o) : 32'h0;

  // Response monitor: every handshake is compared with the head of exp_q.
  always @(negedge clk) begin
    if (!reset_i && resp_v_o && resp_ready_and_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL resp_unexpected: observed data 0x%0h err %0b expected no response",
               resp_data_o, resp_err_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("resp_data", resp_data_o, e[31:0]);
        check("resp_err", resp_err_o, e[32]);
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one request, check its strobes in the transfer cycle, queue its
  // expected response and advance to the next cycle (req_v_i stays high).
  task automatic issue(input string tag, input logic w, input logic [13:0] addr,
                       input logic [1:0] size, input logic [31:0] data,
                       input logic exp_ren, input logic exp_wen, input logic [3:0] exp_mask,
                       input logic [13:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic [32:0] exp_resp);
    req_v_i    = 1'b1;
    req_w_i    = w;
    req_addr_i = addr;
    req_size_i = size;
    req_data_i = data;
    @(negedge clk);
    check({tag, "_ready"}, req_ready_and_o, 1);
    check({tag, "_read_en"}, read_en_o, exp_ren);
    check({tag, "_write_en"}, write_en_o, exp_wen);
    check({tag, "_mask"}, write_mask_o, exp_mask);
    check({tag, "_addr"}, addr_o, exp_addr);
    if (exp_wen) check({tag, "_wdata"}, write_data_o, exp_wdata);
    exp_q.push_back(exp_resp);
    cyc();
  endtask

  // Stop requesting, consume responses until the scoreboard is empty, then
  // confirm the FIFO has nothing left.
  task automatic drain(input string tag);
    req_v_i          = 1'b0;
    resp_ready_and_i = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    check({tag, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_resp_v_idle"}, resp_v_o, 0);
    cyc();
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int acc;

  initial begin
    // reset with a request already presented: no strobe may leak out
    reset_i          = 1'b1;
    req_v_i          = 1'b1;
    req_w_i          = 1'b1;
    req_addr_i       = 14'h0000;
    req_size_i       = 2'd2;
    req_data_i       = 32'hFFFFFFFF;
    resp_ready_and_i = 1'b1;
    @(negedge clk);
    check("rst_ready", req_ready_and_o, 0);
    check("rst_write_en", write_en_o, 0);
    check("rst_read_en", read_en_o, 0);
    check("rst_mask", write_mask_o, 0);
    check("rst_resp_v", resp_v_o, 0);
    cyc();
    reset_i = 1'b0;
    req_v_i = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready_and_o, 1);
    check("post_rst_resp_v", resp_v_o, 0);
    check("post_rst_resp_data", resp_data_o, 0);
    check("post_rst_resp_err", resp_err_o, 0);
    cyc();

    // 1: halfword write, lanes 2..3, response exactly two cycles later
    issue("t1", 1'b1, 14'h0102, 2'd1, 32'h11223344, 1'b0, 1'b1, 4'b1100,
          14'h0100, 32'h33443344, {1'b0, 32'h0});
    req_v_i = 1'b0;
    @(negedge clk);
    check("t1_resp_v_cycle1", resp_v_o, 0);
    check("t1_write_en_off", write_en_o, 0);
    cyc();
    @(negedge clk);
    check("t1_resp_v_cycle2", resp_v_o, 1);
    cyc();
    drain("t1");

    // 2: byte read from lane 3
    issue("t2", 1'b0, 14'h0203, 2'd0, 32'h0, 1'b1, 1'b0, 4'b0000,
          14'h0200, 32'h0, {1'b0, 32'h000000AA});
    drain("t2");

    // 3: misaligned and oversize requests keep their place in the stream
    issue("t3_rd_word", 1'b0, 14'h0204, 2'd2, 32'h0, 1'b1, 1'b0, 4'b0000,
          14'h0204, 32'h0, {1'b0, 32'hBDFB4204});
    issue("t3_misalign", 1'b0, 14'h0001, 2'd2, 32'h0, 1'b0, 1'b0, 4'b0000,
          14'h0000, 32'h0, {1'b1, 32'h0});
    issue("t3_wr_byte", 1'b1, 14'h0008, 2'd0, 32'hDEADBE5A, 1'b0, 1'b1, 4'b0001,
          14'h0008, 32'h5A5A5A5A, {1'b0, 32'h0});
    issue("t3_oversize", 1'b0, 14'h0000, 2'd3, 32'h0, 1'b0, 1'b0, 4'b0000,
          14'h0000, 32'h0, {1'b1, 32'h0});
    issue("t3_rd_half", 1'b0, 14'h0206, 2'd1, 32'h0, 1'b1, 1'b0, 4'b0000,
          14'h0204, 32'h0, {1'b0, 32'h0000BDFB});
    issue("t3_misalign_wr", 1'b1, 14'h0007, 2'd1, 32'h12345678, 1'b0, 1'b0, 4'b0000,
          14'h0004, 32'h0, {1'b1, 32'h0});
    drain("t3");

    // 4: consumer stalled -> only two requests accepted, then one per pop
    resp_ready_and_i = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      req_v_i    = 1'b1;
      req_w_i    = 1'b0;
      req_size_i = 2'd2;
      req_addr_i = 14'(14'h0010 + 4 * acc);
      @(negedge clk);
      if (req_ready_and_o) begin
        exp_q.push_back({1'b0, mem_word(req_addr_i)});
        acc++;
      end
      cyc();
    end
    check("t4_accepted_stalled", acc, 2);
    check("t4_ready_low", req_ready_and_o, 0);
    check("t4_resp_v_held", resp_v_o, 1);
    resp_ready_and_i = 1'b1;
    for (int k = 0; k < 30 && acc < 8; k++) begin
      req_addr_i = 14'(14'h0010 + 4 * acc);
      @(negedge clk);
      if (req_ready_and_o) begin
        exp_q.push_back({1'b0, mem_word(req_addr_i)});
        acc++;
      end
      cyc();
    end
    check("t4_accepted_total", acc, 8);
    drain("t4");

    // 5: streaming reads with the consumer ready -> no bubbles
    for (int k = 0; k < 6; k++) begin
      issue("t5_stream", 1'b0, 14'(14'h0040 + 4 * k), 2'd2, 32'h0, 1'b1, 1'b0, 4'b0000,
            14'(14'h0040 + 4 * k), 32'h0, {1'b0, mem_word(14'(14'h0040 + 4 * k))});
    end
    issue("t5_hi_half", 1'b0, 14'h0042, 2'd1, 32'h0, 1'b1, 1'b0, 4'b0000,
          14'h0040, 32'h0, {1'b0, 32'h0000BFBF});
    issue("t5_lo_half", 1'b0, 14'h0040, 2'd1, 32'h0, 1'b1, 1'b0, 4'b0000,
          14'h0040, 32'h0, {1'b0, 32'h00004040});
    issue("t5_byte1", 1'b0, 14'h0041, 2'd0, 32'h0, 1'b1, 1'b0, 4'b0000,
          14'h0040, 32'h0, {1'b0, 32'h00000040});
    drain("t5");

    // 6: reset with one response queued and one in flight
    resp_ready_and_i = 1'b0;
    issue("t6_a", 1'b0, 14'h0080, 2'd2, 32'h0, 1'b1, 1'b0, 4'b0000,
          14'h0080, 32'h0, {1'b0, mem_word(14'h0080)});
    issue("t6_b", 1'b0, 14'h0084, 2'd2, 32'h0, 1'b1, 1'b0, 4'b0000,
          14'h0084, 32'h0, {1'b0, mem_word(14'h0084)});
    check("t6_queued", resp_v_o, 1);
    reset_i    = 1'b1;
    req_v_i    = 1'b1;
    req_w_i    = 1'b1;
    req_addr_i = 14'h0090;
    req_size_i = 2'd2;
    exp_q.delete();
    @(negedge clk);
    check("t6_rst_write_en", write_en_o, 0);
    check("t6_rst_read_en", read_en_o, 0);
    check("t6_rst_ready", req_ready_and_o, 0);
    cyc();
    reset_i = 1'b0;
    req_v_i = 1'b0;
    @(negedge clk);
    check("t6_resp_v_cleared", resp_v_o, 0);
    check("t6_ready_back", req_ready_and_o, 1);
    cyc();
    issue("t6_c", 1'b0, 14'h00A0, 2'd2, 32'h0, 1'b1, 1'b0, 4'b0000,
          14'h00A0, 32'h0, {1'b0, mem_word(14'h00A0)});
    issue("t6_d", 1'b1, 14'h00A4, 2'd2, 32'hCAFEF00D, 1'b0, 1'b1, 4'b1111,
          14'h00A4, 32'hCAFEF00D, {1'b0, 32'h0});
    check("t6_credits_used", req_ready_and_o, 0);
    drain("t6");

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
